// File: rtl/microcode_pkg.sv
// Shared definitions for the microcode sequencer: opcodes, microinstruction field
// positions and the sequencer state encoding.
package microcode_pkg;

    localparam logic [3:0] OP_NEXT  = 4'h0;
    localparam logic [3:0] OP_JMP   = 4'h1;
    localparam logic [3:0] OP_JC    = 4'h2;
    localparam logic [3:0] OP_JNC   = 4'h3;
    localparam logic [3:0] OP_CALL  = 4'h4;
    localparam logic [3:0] OP_RET   = 4'h5;
    localparam logic [3:0] OP_LDCNT = 4'h6;
    localparam logic [3:0] OP_LOOP  = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'h8;

    localparam int unsigned OP_HI  = 31;
    localparam int unsigned OP_LO  = 28;
    localparam int unsigned SEL_HI = 27;
    localparam int unsigned SEL_LO = 24;
    localparam int unsigned TGT_HI = 23;
    localparam int unsigned TGT_LO = 16;
    localparam int unsigned CW_HI  = 15;
    localparam int unsigned CW_LO  = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2
    } state_e;

endpackage

// File: rtl/microcode_stack.sv
// Return-address LIFO for the microcode sequencer. Push when full and pop when
// empty are ignored; the sequencer treats those cases as faults before issuing them.
module microcode_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    sp_q;

    assign full  = (sp_q == PW'(DEPTH));
    assign empty = (sp_q == '0);
    assign dout  = mem_q[IW'(sp_q - 1'b1)];

    // Storage needs no reset; only the pointer defines what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[IW'(sp_q)] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + 1'b1;
        end else if (pop && !empty) begin
            sp_q <= sp_q - 1'b1;
        end
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Microprogram sequencer: fetches from a 1-cycle-latency microcode RAM, executes one
// microinstruction per FETCH/EXEC pair and drives the control word to the datapath.
module microcode_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic [ADDR_WIDTH-1:0] uc_addr,
    input  logic [31:0]           uc_data,
    input  logic [15:0]           cond,
    input  logic                  stall,
    output logic [15:0]           ctrl_out,
    output logic                  ctrl_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    import microcode_pkg::*;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc, tgt_addr, stk_top;
    logic [7:0]            cnt_q, cnt_d, tgt;
    logic [3:0]            op, sel;
    logic                  cond_bit, push, pop, stk_full, stk_empty;
    logic                  done_q, done_d, error_q, error_d, fault;

    assign op       = uc_data[OP_HI:OP_LO];
    assign sel      = uc_data[SEL_HI:SEL_LO];
    assign tgt      = uc_data[TGT_HI:TGT_LO];
    assign tgt_addr = tgt[ADDR_WIDTH-1:0];
    assign pc_inc   = pc_q + 1'b1;
    assign cond_bit = cond[sel];

    microcode_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        error_d = error_q;
        push    = 1'b0;
        pop     = 1'b0;
        fault   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = start_addr;
                    error_d = 1'b0;
                end
            end
            StFetch: state_d = StExec;
            StExec: begin
                // While stalled pc, cnt and stack hold so the RAM keeps re-reading this word.
                if (!stall) begin
                    state_d = StFetch;
                    pc_d    = pc_inc;
                    case (op)
                        OP_NEXT:  ;
                        OP_JMP:   pc_d = tgt_addr;
                        OP_JC:    if (cond_bit) pc_d = tgt_addr;
                        OP_JNC:   if (!cond_bit) pc_d = tgt_addr;
                        OP_CALL: begin
                            if (stk_full) begin
                                fault = 1'b1;
                            end else begin
                                push = 1'b1;
                                pc_d = tgt_addr;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                fault = 1'b1;
                            end else begin
                                pop  = 1'b1;
                                pc_d = stk_top;
                            end
                        end
                        OP_LDCNT: cnt_d = tgt;
                        OP_LOOP: begin
                            if (cnt_q != 8'd0) begin
                                cnt_d = cnt_q - 8'd1;
                                pc_d  = tgt_addr;
                            end
                        end
                        OP_HALT: begin
                            state_d = StIdle;
                            pc_d    = pc_q;
                            done_d  = 1'b1;
                        end
                        default: fault = 1'b1;
                    endcase
                    if (fault) begin
                        state_d = StIdle;
                        pc_d    = pc_q;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign uc_addr    = pc_q;
    assign busy       = (state_q != StIdle);
    assign ctrl_valid = (state_q == StExec);
    assign ctrl_out   = (state_q == StExec) ? uc_data[CW_HI:CW_LO] : 16'h0000;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed programs plus random ones, each checked
// cycle by cycle against an instruction-level reference model of the sequencer.
module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, stall;
    logic [7:0]  start_addr, uc_addr;
    logic [31:0] uc_data;
    logic [15:0] cond, ctrl_out;
    logic        ctrl_valid, busy, done, error;

    logic [31:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state persists across runs until reset.
    logic [7:0]  m_cnt;
    logic [7:0]  m_stk[$];
    logic [7:0]  exp_addr[$];
    logic [15:0] exp_cw[$];
    int          exp_end;  // 0 halt, 1 fault, 2 still running
    logic [7:0]  obs_addr[$];
    logic [15:0] obs_cw[$];

    always #5 clk = ~clk;

    always @(posedge clk) uc_data <= mem[uc_addr];

    microcode_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .uc_addr    (uc_addr),
        .uc_data    (uc_data),
        .cond       (cond),
        .stall      (stall),
        .ctrl_out   (ctrl_out),
        .ctrl_valid (ctrl_valid),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    function automatic logic [31:0] ins(int op, int sel, int tgt, int cw);
        return {op[3:0], sel[3:0], tgt[7:0], cw[15:0]};
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_run(logic [7:0] sa, logic [15:0] cv, int max_steps);
        logic [7:0]  pc;
        logic [31:0] w;
        logic [3:0]  op, sel;
        logic [7:0]  tgt;
        pc = sa;
        exp_addr.delete();
        exp_cw.delete();
        exp_end = 2;
        for (int s = 0; s < max_steps && exp_end == 2; s++) begin
            w   = mem[pc];
            op  = w[31:28];
            sel = w[27:24];
            tgt = w[23:16];
            exp_addr.push_back(pc);
            exp_cw.push_back(w[15:0]);
            case (op)
                4'd0: pc = pc + 8'd1;
                4'd1: pc = tgt;
                4'd2: pc = cv[sel] ? tgt : pc + 8'd1;
                4'd3: pc = cv[sel] ? pc + 8'd1 : tgt;
                4'd4: begin
                    if (m_stk.size() >= 4) exp_end = 1;
                    else begin
                        m_stk.push_back(pc + 8'd1);
                        pc = tgt;
                    end
                end
                4'd5: begin
                    if (m_stk.size() == 0) exp_end = 1;
                    else pc = m_stk.pop_back();
                end
                4'd6: begin
                    m_cnt = tgt;
                    pc    = pc + 8'd1;
                end
                4'd7: begin
                    if (m_cnt != 8'd0) begin
                        m_cnt = m_cnt - 8'd1;
                        pc    = tgt;
                    end else pc = pc + 8'd1;
                end
                4'd8: exp_end = 0;
                default: exp_end = 1;
            endcase
        end
    endtask

    // Called at a falling edge; asserts reset and checks outputs before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_uc_addr", 32'(uc_addr), 32'd0);
        check_eq("rst_ctrl_out", 32'(ctrl_out), 32'd0);
        check_eq("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        m_cnt = 8'd0;
        m_stk.delete();
    endtask

    // Called at a falling edge with the DUT idle (or in its done cycle).
    // stall_pct >= 100 means exactly three stall cycles on every instruction.
    task automatic run_prog(logic [7:0] sa, logic [15:0] cv, int unsigned stall_pct,
                            int max_steps, bit chain);
        bit s;
        cond = cv;
        model_run(sa, cv, max_steps);
        obs_addr.delete();
        obs_cw.delete();
        start      = 1'b1;
        start_addr = sa;
        for (int i = 0; i < exp_addr.size(); i++) begin
            @(negedge clk);
            start = 1'b0;
            check_eq("fetch_busy", 32'(busy), 32'd1);
            check_eq("fetch_valid", 32'(ctrl_valid), 32'd0);
            check_eq("fetch_cw", 32'(ctrl_out), 32'd0);
            check_eq("fetch_addr", 32'(uc_addr), 32'(exp_addr[i]));
            check_eq("fetch_error", 32'(error), 32'd0);
            check_eq("fetch_done", 32'(done), 32'd0);
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                check_eq("exec_valid", 32'(ctrl_valid), 32'd1);
                check_eq("exec_cw", 32'(ctrl_out), 32'(exp_cw[i]));
                check_eq("exec_addr", 32'(uc_addr), 32'(exp_addr[i]));
                check_eq("exec_busy", 32'(busy), 32'd1);
                if (stall_pct >= 100) s = (k < 3);
                else s = (k < 8) && ($urandom_range(0, 99) < stall_pct);
                stall = s;
                if (!s) begin
                    obs_addr.push_back(uc_addr);
                    obs_cw.push_back(ctrl_out);
                    break;
                end
            end
        end
        if (exp_end != 2) begin
            @(negedge clk);
            check_eq("end_done", 32'(done), 32'(exp_end == 0));
            check_eq("end_busy", 32'(busy), 32'd0);
            check_eq("end_error", 32'(error), 32'(exp_end == 1));
            check_eq("end_valid", 32'(ctrl_valid), 32'd0);
            check_eq("end_cw", 32'(ctrl_out), 32'd0);
            if (!chain) begin
                @(negedge clk);
                check_eq("after_done", 32'(done), 32'd0);
                check_eq("after_error", 32'(error), 32'(exp_end == 1));
            end
        end
    endtask

    initial begin
        int body;
        int pick;
        rst        = 1'b1;
        start      = 1'b0;
        stall      = 1'b0;
        cond       = 16'h0000;
        start_addr = 8'h00;
        for (int a = 0; a < 256; a++) mem[a] = ins(8, 0, 0, 16'hEEEE);
        @(negedge clk);
        do_reset();

        // Straight-line run
        mem[8'h10] = ins(0, 0, 0, 1);
        mem[8'h11] = ins(0, 0, 0, 2);
        mem[8'h12] = ins(8, 0, 0, 3);
        run_prog(8'h10, 16'h0000, 0, 20, 1'b0);
        check_eq("line_len", 32'(obs_cw.size()), 32'd3);
        check_eq("line_addr2", 32'(obs_addr[2]), 32'h12);
        check_eq("line_cw2", 32'(obs_cw[2]), 32'h3);

        // Conditional branches on cond[3]
        mem[8'h20] = ins(2, 3, 8'h40, 16'h2020);
        mem[8'h21] = ins(8, 0, 0, 16'h2121);
        mem[8'h30] = ins(3, 3, 8'h40, 16'h3030);
        mem[8'h31] = ins(8, 0, 0, 16'h3131);
        mem[8'h40] = ins(8, 0, 0, 16'h4040);
        run_prog(8'h20, 16'h0008, 0, 20, 1'b0);
        check_eq("jc_taken", 32'(obs_addr[1]), 32'h40);
        run_prog(8'h20, 16'hFFF7, 0, 20, 1'b0);
        check_eq("jc_not_taken", 32'(obs_addr[1]), 32'h21);
        run_prog(8'h30, 16'h0008, 0, 20, 1'b0);
        check_eq("jnc_not_taken", 32'(obs_addr[1]), 32'h31);
        run_prog(8'h30, 16'h0000, 0, 20, 1'b0);
        check_eq("jnc_taken", 32'(obs_addr[1]), 32'h40);

        // Call / return
        do_reset();
        mem[8'h05] = ins(4, 0, 8'h40, 16'h0005);
        mem[8'h40] = ins(5, 0, 0, 16'h0040);
        mem[8'h06] = ins(8, 0, 0, 16'h0006);
        run_prog(8'h05, 16'h0000, 0, 20, 1'b0);
        check_eq("ret_resume", 32'(obs_addr[2]), 32'h06);

        // Stack overflow on the fifth nested call
        do_reset();
        for (int i = 0; i < 5; i++) mem[8'h50 + i] = ins(4, 0, 8'h51 + i, i);
        run_prog(8'h50, 16'h0000, 0, 20, 1'b0);
        check_eq("ovf_error", 32'(error), 32'd1);
        check_eq("ovf_done", 32'(done), 32'd0);
        check_eq("ovf_execs", 32'(obs_cw.size()), 32'd5);

        // Counted loop
        do_reset();
        mem[8'h00] = ins(6, 0, 3, 16'h00A0);
        mem[8'h01] = ins(0, 0, 0, 16'hB0D1);
        mem[8'h02] = ins(7, 0, 1, 16'h00A2);
        mem[8'h03] = ins(8, 0, 0, 16'h00A3);
        run_prog(8'h00, 16'h0000, 30, 40, 1'b0);
        body = 0;
        foreach (obs_cw[i]) if (obs_cw[i] == 16'hB0D1) body++;
        check_eq("loop_body_count", 32'(body), 32'd4);
        check_eq("loop_last_cw", 32'(obs_cw[obs_cw.size() - 1]), 32'h00A3);

        // Reset mid-loop
        run_prog(8'h00, 16'h0000, 0, 5, 1'b0);
        do_reset();

        // Address wrap
        mem[8'hFF] = ins(0, 0, 0, 16'hFFFF);
        mem[8'h00] = ins(8, 0, 0, 16'h0001);
        run_prog(8'hFF, 16'h0000, 0, 10, 1'b0);
        check_eq("wrap_addr", 32'(obs_addr[1]), 32'h00);

        // Three stall cycles on every instruction
        run_prog(8'h10, 16'h0000, 100, 20, 1'b0);

        // Illegal opcode, then the next start clears error
        mem[8'h60] = ins(0, 0, 0, 16'h6060);
        mem[8'h61] = ins(15, 0, 0, 16'h6161);
        run_prog(8'h60, 16'h0000, 0, 10, 1'b0);
        check_eq("illegal_error", 32'(error), 32'd1);
        run_prog(8'h10, 16'h0000, 0, 20, 1'b0);

        // Random programs in 0xA0..0xBF, random stalls, back-to-back starts
        mem[8'hC0] = ins(8, 0, 0, 16'h0C0C);
        for (int r = 0; r < 40; r++) begin
            for (int a = 8'hA0; a < 8'hC0; a++) begin
                pick = int'($urandom_range(0, 19));
                if (pick < 4) pick = 0;
                else if (pick < 6) pick = 1;
                else if (pick < 8) pick = 2;
                else if (pick < 10) pick = 3;
                else if (pick < 12) pick = 4;
                else if (pick < 14) pick = 5;
                else if (pick < 15) pick = 6;
                else if (pick < 17) pick = 7;
                else if (pick < 19) pick = 8;
                else pick = int'($urandom_range(9, 15));
                mem[a] = ins(pick, int'($urandom_range(0, 15)),
                             (pick == 6) ? int'($urandom_range(0, 5))
                                         : int'($urandom_range(8'hA0, 8'hBF)),
                             int'($urandom_range(0, 16'hFFFF)));
            end
            run_prog(8'(8'hA0 + $urandom_range(0, 31)), 16'($urandom_range(0, 16'hFFFF)),
                     25, 30, 1'($urandom_range(0, 1)));
            if (exp_end == 2 || $urandom_range(0, 4) == 0) do_reset();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
